// File: rtl/mmm_pkg.sv
// Shared widths for the fetch/predict cluster.
package mmm_pkg;
  localparam int XLEN = 32;
  localparam int HLEN = 10;
endpackage

// File: rtl/bpu_res_arbiter_if.sv
// Requester-side resolution handshakes and the single BPU update port of bpu_res_arbiter.
interface bpu_res_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int XLEN = mmm_pkg::XLEN;
  localparam int HLEN = mmm_pkg::HLEN;

  logic                    flush_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*XLEN-1:0]   req_pc_i;
  logic [N_REQ*HLEN-1:0]   req_index_i;
  logic [N_REQ*XLEN-1:0]   req_target_i;
  logic [N_REQ-1:0]        req_taken_i;
  logic [N_REQ-1:0]        req_mispredict_i;

  logic                    res_valid_o;
  logic [XLEN-1:0]         res_pc_o;
  logic [HLEN-1:0]         res_index_o;
  logic [XLEN-1:0]         res_target_o;
  logic                    res_taken_o;
  logic                    res_mispredict_o;
  logic                    pending_o;

  modport master (
    output flush_i, req_valid_i, req_pc_i, req_index_i, req_target_i,
           req_taken_i, req_mispredict_i,
    input  req_ready_o, res_valid_o, res_pc_o, res_index_o, res_target_o,
           res_taken_o, res_mispredict_o, pending_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_pc_i, req_index_i, req_target_i,
           req_taken_i, req_mispredict_i,
    output req_ready_o, res_valid_o, res_pc_o, res_index_o, res_target_o,
           res_taken_o, res_mispredict_o, pending_o
  );
endinterface

// File: rtl/bpu_res_arbiter.sv
// Per-requester resolution FIFOs feeding one registered BPU update per cycle.
// BPU_ARB_MISP_PRIO_EN: when defined, mispredicted heads win over correct ones.
module bpu_res_arbiter #(
  parameter int N_REQ = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  bpu_res_arbiter_if.slave bus
);
  localparam int XLEN = mmm_pkg::XLEN;
  localparam int HLEN = mmm_pkg::HLEN;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] RR_ZERO  = {GW{1'b0}};
  localparam logic [GW-1:0] RR_ONE   = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] RR_LAST  = GW'(N_REQ - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } entry_t;

  localparam entry_t ENTRY_ZERO = {$bits(entry_t){1'b0}};

  entry_t           fifo_mem_r [N_REQ][DEPTH];
  logic [AW-1:0]    wr_ptr_r   [N_REQ];
  logic [AW-1:0]    rd_ptr_r   [N_REQ];
  logic [CW-1:0]    count_r    [N_REQ];
  logic [GW-1:0]    rr_ptr_r;
  entry_t           res_r;
  logic             res_valid_r;

  entry_t           req_entry_s [N_REQ];
  entry_t           head_s      [N_REQ];
  logic [N_REQ-1:0] ready_s;
  logic [N_REQ-1:0] push_s;
  logic [N_REQ-1:0] pop_s;
  logic [N_REQ-1:0] nonempty_s;
  logic [N_REQ-1:0] misp_head_s;
  logic [N_REQ-1:0] cand_s;
  logic             grant_valid_s;
  logic [GW-1:0]    grant_idx_s;
  entry_t           grant_entry_s;

  // Decode requester slices and expose each FIFO head
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_entry_s[i].pc         = bus.req_pc_i[i*XLEN +: XLEN];
      req_entry_s[i].index      = bus.req_index_i[i*HLEN +: HLEN];
      req_entry_s[i].target     = bus.req_target_i[i*XLEN +: XLEN];
      req_entry_s[i].taken      = bus.req_taken_i[i];
      req_entry_s[i].mispredict = bus.req_mispredict_i[i];
      // Ready looks only at the registered count: a full FIFO never accepts
      // in the same cycle it is popped.
      ready_s[i]     = (count_r[i] != FULL_CNT);
      push_s[i]      = bus.req_valid_i[i] & ready_s[i];
      nonempty_s[i]  = (count_r[i] != CNT_ZERO);
      head_s[i]      = fifo_mem_r[i][rd_ptr_r[i]];
      misp_head_s[i] = nonempty_s[i] & head_s[i].mispredict;
    end
  end

  // Pick one non-empty head, scanning upward from rr_ptr within the winning class
  always_comb begin
`ifdef BPU_ARB_MISP_PRIO_EN
    cand_s = (|misp_head_s) ? misp_head_s : nonempty_s;
`else
    cand_s = nonempty_s;
`endif
    grant_valid_s = 1'b0;
    grant_idx_s   = RR_ZERO;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_valid_s && cand_s[j] && (((int'(rr_ptr_r) + k) % N_REQ) == j)) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = GW'(j);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  // Route the granted head to the output register and flag its pop
  always_comb begin
    grant_entry_s = ENTRY_ZERO;
    pop_s         = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_valid_s && (grant_idx_s == GW'(i))) begin
        pop_s[i]      = 1'b1;
        grant_entry_s = head_s[i];
      end else begin
        pop_s[i] = 1'b0;
      end
    end
  end

  // FIFO payload storage; slots are only read once counted, so no reset is needed
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push_s[i] && !bus.flush_i) begin
        fifo_mem_r[i][wr_ptr_r[i]] <= req_entry_s[i];
      end
    end
  end

  // FIFO pointers/counts, round-robin pointer and the BPU update register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr_r[i] <= PTR_ZERO;
        rd_ptr_r[i] <= PTR_ZERO;
        count_r[i]  <= CNT_ZERO;
      end
      rr_ptr_r    <= RR_ZERO;
      res_r       <= ENTRY_ZERO;
      res_valid_r <= 1'b0;
    end else if (bus.flush_i) begin
      // Flush drops queued work and the in-flight pop but keeps rr fairness state.
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr_r[i] <= PTR_ZERO;
        rd_ptr_r[i] <= PTR_ZERO;
        count_r[i]  <= CNT_ZERO;
      end
      res_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
          2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
          default: count_r[i] <= count_r[i];
        endcase
      end
      if (grant_valid_s) begin
        rr_ptr_r    <= (grant_idx_s == RR_LAST) ? RR_ZERO : (grant_idx_s + RR_ONE);
        res_r       <= grant_entry_s;
        res_valid_r <= 1'b1;
      end else begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o      = ready_s;
  assign bus.pending_o        = |nonempty_s;
  assign bus.res_valid_o      = res_valid_r;
  assign bus.res_pc_o         = res_r.pc;
  assign bus.res_index_o      = res_r.index;
  assign bus.res_target_o     = res_r.target;
  assign bus.res_taken_o      = res_r.taken;
  assign bus.res_mispredict_o = res_r.mispredict;

endmodule

// File: tb/tb_bpu_res_arbiter.sv
// Directed bench for bpu_res_arbiter (N_REQ=2, DEPTH=4); expectations follow BPU_ARB_MISP_PRIO_EN.
module tb_bpu_res_arbiter;
  localparam int N_REQ = 2;
  localparam int DEPTH = 4;
  localparam int XLEN  = mmm_pkg::XLEN;
  localparam int HLEN  = mmm_pkg::HLEN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bpu_res_arbiter_if #(.N_REQ(N_REQ)) bus ();

  bpu_res_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [XLEN-1:0] pc,
                       input logic [HLEN-1:0] idx, input logic [XLEN-1:0] tgt,
                       input logic tk, input logic mis);
    bus.req_valid_i[i]                = v;
    bus.req_pc_i[i*XLEN +: XLEN]      = pc;
    bus.req_index_i[i*HLEN +: HLEN]   = idx;
    bus.req_target_i[i*XLEN +: XLEN]  = tgt;
    bus.req_taken_i[i]                = tk;
    bus.req_mispredict_i[i]           = mis;
  endtask

  task automatic idle();
    bus.flush_i = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      drive(i, 1'b0, 32'h0, 10'h0, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.res_valid_o); end
    checks++; if (bus.pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b want 0", bus.pending_o); end
    checks++; if (bus.req_ready_o !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", bus.req_ready_o); end
    checks++; if (bus.res_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.res_pc_o); end
    checks++; if (bus.res_target_o !== 32'h0) begin errors++; $display("FAIL reset_target got %h want 0", bus.res_target_o); end
    checks++; if (bus.res_index_o !== 10'h0) begin errors++; $display("FAIL reset_index got %h want 0", bus.res_index_o); end
    checks++; if ({bus.res_taken_o, bus.res_mispredict_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.res_taken_o, bus.res_mispredict_o); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %0b want 0", bus.res_valid_o); end
  endtask

  task automatic test_single_request();
    do_reset();
    drive(0, 1'b1, 32'h100, 10'h2A, 32'h200, 1'b1, 1'b1);
    step();
    idle();
    checks++; if (bus.pending_o !== 1'b1) begin errors++; $display("FAIL single_pending got %0b want 1", bus.pending_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", bus.res_valid_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.res_valid_o); end
    checks++; if (bus.res_pc_o !== 32'h100) begin errors++; $display("FAIL single_pc got %h want 100", bus.res_pc_o); end
    checks++; if (bus.res_index_o !== 10'h2A) begin errors++; $display("FAIL single_index got %h want 2a", bus.res_index_o); end
    checks++; if (bus.res_target_o !== 32'h200) begin errors++; $display("FAIL single_target got %h want 200", bus.res_target_o); end
    checks++; if ({bus.res_taken_o, bus.res_mispredict_o} !== 2'b11) begin errors++; $display("FAIL single_flags got %b%b want 11", bus.res_taken_o, bus.res_mispredict_o); end
    checks++; if (bus.pending_o !== 1'b0) begin errors++; $display("FAIL single_drained got %0b want 0", bus.pending_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b want 0", bus.res_valid_o); end
    checks++; if (bus.res_pc_o !== 32'h100) begin errors++; $display("FAIL single_hold got %h want 100", bus.res_pc_o); end
  endtask

  task automatic test_round_robin();
    logic [XLEN-1:0] exp_pc [6];
    exp_pc = '{32'h10, 32'h20, 32'h14, 32'h24, 32'h18, 32'h28};
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 3) begin
        drive(0, 1'b1, 32'h10 + 32'(cyc * 4), 10'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 1'b1, 32'h20 + 32'(cyc * 4), 10'h0, 32'h0, 1'b0, 1'b0);
      end else begin
        idle();
      end
      step();
      if (cyc >= 1 && cyc <= 6) begin
        checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %0b want 1", cyc - 1, bus.res_valid_o); end
        checks++; if (bus.res_pc_o !== exp_pc[cyc-1]) begin errors++; $display("FAIL rr_pc[%0d] got %h want %h", cyc - 1, bus.res_pc_o, exp_pc[cyc-1]); end
      end else if (cyc == 7) begin
        checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL rr_end got %0b want 0", bus.res_valid_o); end
      end
    end
  endtask

  task automatic test_misp_priority();
    logic [XLEN-1:0] exp_pc [3];
`ifdef BPU_ARB_MISP_PRIO_EN
    exp_pc = '{32'h40, 32'h30, 32'h34};
`else
    exp_pc = '{32'h30, 32'h40, 32'h34};
`endif
    do_reset();
    drive(0, 1'b1, 32'h30, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h40, 10'h0, 32'h0, 1'b1, 1'b1);
    step();
    drive(0, 1'b1, 32'h34, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL prio_valid[%0d] got %0b want 1", k, bus.res_valid_o); end
      checks++; if (bus.res_pc_o !== exp_pc[k]) begin errors++; $display("FAIL prio_pc[%0d] got %h want %h", k, bus.res_pc_o, exp_pc[k]); end
      checks++; if (bus.res_mispredict_o !== (exp_pc[k] == 32'h40)) begin errors++; $display("FAIL prio_misp[%0d] got %0b", k, bus.res_mispredict_o); end
      step();
    end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL prio_end got %0b want 0", bus.res_valid_o); end
  endtask

  task automatic test_full();
    logic [XLEN-1:0] exp_out [13];
    logic            exp_rdy [13];
    int   n1;
    logic acc1;
`ifdef BPU_ARB_MISP_PRIO_EN
    exp_out = '{32'h0, 32'h0, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h0};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_out = '{32'h0, 32'h0, 32'h40, 32'h80, 32'h44, 32'h84, 32'h48, 32'h88, 32'h4C, 32'h8C, 32'h90, 32'h94, 32'h0};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    n1 = 0;
    for (int c = 0; c < 13; c++) begin
      checks++; if (bus.req_ready_o[1] !== exp_rdy[c]) begin errors++; $display("FAIL full_ready1[%0d] got %0b want %0b", c, bus.req_ready_o[1], exp_rdy[c]); end
      checks++; if (bus.res_valid_o !== ((exp_out[c] != 32'h0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL full_valid[%0d] got %0b", c, bus.res_valid_o); end
      if (exp_out[c] != 32'h0) begin
        checks++; if (bus.res_pc_o !== exp_out[c]) begin errors++; $display("FAIL full_pc[%0d] got %h want %h", c, bus.res_pc_o, exp_out[c]); end
      end
      if (c < 4) drive(0, 1'b1, 32'h40 + 32'(c * 4), 10'h0, 32'h0, 1'b1, 1'b1);
      else       drive(0, 1'b0, 32'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      if (n1 < 6) drive(1, 1'b1, 32'h80 + 32'(n1 * 4), 10'h0, 32'h0, 1'b0, 1'b0);
      else        drive(1, 1'b0, 32'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      acc1 = bus.req_valid_i[1] & bus.req_ready_o[1];
      step();
      if (acc1) n1++;
    end
    checks++; if (n1 != 6) begin errors++; $display("FAIL full_accepted got %0d want 6", n1); end
    checks++; if (bus.pending_o !== 1'b0) begin errors++; $display("FAIL full_pending got %0b want 0", bus.pending_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 1'b1, 32'h50, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h58, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(0, 1'b1, 32'h54, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h5C, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    checks++; if (bus.res_pc_o !== 32'h50 || bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre got %0b/%h want 1/50", bus.res_valid_o, bus.res_pc_o); end
    idle();
    bus.flush_i = 1'b1;
    drive(0, 1'b1, 32'hBAD0, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.res_valid_o); end
    checks++; if (bus.pending_o !== 1'b0) begin errors++; $display("FAIL flush_pending got %0b want 0", bus.pending_o); end
    checks++; if (bus.req_ready_o !== 2'b11) begin errors++; $display("FAIL flush_ready got %b want 11", bus.req_ready_o); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d] got %0b want 0 pc %h", k, bus.res_valid_o, bus.res_pc_o); end
    end
    drive(0, 1'b1, 32'h60, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h70, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    step();
    checks++; if (bus.res_pc_o !== 32'h70 || bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL flush_rr_first got %0b/%h want 1/70", bus.res_valid_o, bus.res_pc_o); end
    step();
    checks++; if (bus.res_pc_o !== 32'h60 || bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL flush_rr_second got %0b/%h want 1/60", bus.res_valid_o, bus.res_pc_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b0 || bus.pending_o !== 1'b0) begin errors++; $display("FAIL flush_end got %0b/%0b want 0/0", bus.res_valid_o, bus.pending_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1'b1, 32'hA0, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'hB0, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(0, 1'b1, 32'hA4, 10'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'hB4, 10'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    checks++; if (bus.res_valid_o !== 1'b1 || bus.pending_o !== 1'b1) begin errors++; $display("FAIL arst_pre got %0b/%0b want 1/1", bus.res_valid_o, bus.pending_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", bus.res_valid_o); end
    checks++; if (bus.pending_o !== 1'b0) begin errors++; $display("FAIL arst_pending got %0b want 0", bus.pending_o); end
    checks++; if (bus.req_ready_o !== 2'b11) begin errors++; $display("FAIL arst_ready got %b want 11", bus.req_ready_o); end
    checks++; if (bus.res_pc_o !== 32'h0) begin errors++; $display("FAIL arst_pc got %h want 0", bus.res_pc_o); end
    #2;
    rst_n = 1'b1;
    step();
    step();
    checks++; if (bus.res_valid_o !== 1'b0 || bus.pending_o !== 1'b0) begin errors++; $display("FAIL arst_after got %0b/%0b want 0/0", bus.res_valid_o, bus.pending_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_request();
    test_round_robin();
    test_misp_priority();
    test_full();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
